// File: rtl/fetch_unit_pb.sv
// fetch_unit_pb: PC-sequenced instruction fetch with a DEPTH-entry prefetch FIFO and branch redirect flush
module fetch_unit_pb #(
  parameter int unsigned     AW       = 24,
  parameter int unsigned     IW       = 24,
  parameter int unsigned     INC      = 1,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [AW-1:0]                redirect_pc,
  output logic                         imem_en,
  output logic [AW-1:0]                imem_addr,
  input  logic [IW-1:0]                imem_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IW-1:0]                out_instr,
  output logic [AW-1:0]                out_pc,
  output logic [AW-1:0]                out_pc_next,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
  localparam int unsigned   CW      = $clog2(DEPTH+1);
  localparam int unsigned   CW1     = CW + 1;
  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PC_STEP = AW'(INC);
  logic [AW-1:0] pc_q, inflight_pc_q;
  logic          inflight_q;
  logic [IW-1:0] instr_q [DEPTH];
  logic [AW-1:0] epc_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic [CW1-1:0] committed;
  logic pop, push, issue;
  // committed counts FIFO slots already owed to buffered or in-flight data
  always_comb begin
    out_valid   = (count_q != '0) & !redirect_valid & !rst;
    pop         = out_valid & out_ready;
    push        = inflight_q & !redirect_valid;
    committed   = CW1'(count_q) + CW1'(inflight_q) - CW1'(pop);
    issue       = !rst & !redirect_valid & (committed < CW1'(DEPTH));
    imem_en     = issue;
    imem_addr   = pc_q;
    out_instr   = instr_q[rd_q];
    out_pc      = epc_q[rd_q];
    out_pc_next = epc_q[rd_q] + PC_STEP;
    fifo_count  = count_q;
    count_d     = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge CLK) begin
    if (rst || redirect_valid) begin
      pc_q       <= rst ? RESET_PC : redirect_pc;
      inflight_q <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
    end else begin
      if (issue) pc_q <= pc_q + PC_STEP;
      inflight_q <= issue;
      rd_q       <= rd_q + PW'(pop);
      wr_q       <= wr_q + PW'(push);
      count_q    <= count_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (issue) inflight_pc_q <= pc_q;
    if (push && !rst) begin
      instr_q[wr_q] <= imem_rdata;
      epc_q[wr_q]   <= inflight_pc_q;
    end
  end
endmodule

// File: doc/fetch_unit_pb.md
# fetch_unit_pb

Parametrised instruction fetch unit with a prefetch buffer. It replaces the fixed 24-bit single-register fetch stage. It keeps a PC, issues sequential reads to a synchronous instruction memory with 1-cycle read latency, and buffers returned instructions in a DEPTH-entry FIFO. It presents them to decode over a valid/ready handshake and supports a branch redirect that flushes all fetched and in-flight instructions.

## Interface
- AW, 24, address/PC width in bits
- IW, 24, instruction width in bits
- INC, 1, PC increment per instruction (address units)
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- CLK  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  load redirect_pc into the PC and flush the FIFO and in-flight read
- redirect_pc  in  AW  redirect target
- imem_en  out  1  memory read request this cycle
- imem_addr  out  AW  read address (current PC)
- imem_rdata  in  IW  read data, valid the cycle after imem_en=1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_instr  out  IW  head instruction
- out_pc  out  AW  PC of head instruction
- out_pc_next  out  AW  out_pc + INC (mod 2^AW)
- fifo_count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- State:
  - pc register
  - inflight flag with the captured inflight_pc
  - FIFO of {instr, pc} entries with rd/wr pointers and count
- pop = out_valid & out_ready & !redirect_valid.
- issue = !rst & !redirect_valid & (count + inflight − pop < DEPTH).
- imem_en = issue; imem_addr = pc.
- On issue:
  - pc ← pc + INC, truncated to AW bits (wraps).
  - inflight ← 1; inflight_pc ← pc.
- No issue: inflight ← 0.
- Response: when inflight=1 and redirect_valid=0, push {imem_rdata, inflight_pc}. The credit check guarantees space, so push to a full FIFO never occurs.
- Simultaneous push and pop: both happen; count unchanged; pointers each advance modulo DEPTH.
- Redirect, in the cycle redirect_valid=1:
  - out_valid is forced 0.
  - No issue, no pop, no push; any response arriving this cycle is discarded.
  - At the edge: FIFO emptied (count=0, pointers reset), inflight ← 0, pc ← redirect_pc.
- Reset (rst=1 at an edge), including mid-stream:
  - pc ← RESET_PC; FIFO emptied; inflight ← 0.
  - While rst=1: imem_en=0 and out_valid=0.
- out_valid = (count≠0) & !redirect_valid.
- out_instr, out_pc and out_pc_next come from the head entry. Their values are don't-care when out_valid=0.
- Holding: while out_valid=1 and out_ready=0, the head fields hold stable.

## Timing
- Reset values: imem_en=0, out_valid=0, fifo_count=0, pc=RESET_PC.
- Issue-to-output latency is 2 cycles:
  - cycle t: issue.
  - cycle t+1: imem_rdata sampled and pushed at the t+1 edge.
  - cycle t+2: out_valid=1.
- First instruction after reset release: issued in the first cycle with rst=0 (cycle 0), visible at cycle 2.
- Redirect asserted in cycle r: first fetch of the target issued in r+1, out_valid in r+3 (3-cycle branch penalty).
- Steady state with out_ready=1: one instruction per cycle for every DEPTH≥2.
- Backpressure: with out_ready=0, fetching stops once count+inflight=DEPTH. Resumes issuing in the same cycle as the first pop.

## Test plan
- Reset then free-run: RESET_PC=0, INC=1, out_ready=1.
  - out_valid first high 2 cycles after reset release.
  - out_pc sequence 0,1,2,3…; out_pc_next = out_pc+1.
  - Gap-free one-per-cycle output.
- Backpressure: hold out_ready=0 from cycle 0.
  - Exactly DEPTH=4 issues, fifo_count saturates at 4, imem_en=0 afterwards.
  - Releasing out_ready gives PCs 0..3 in order, then 4 with no gap and no loss.
- Redirect mid-stream: redirect_valid=1 with redirect_pc=0x100 while an issue is in flight.
  - out_valid=0 that cycle.
  - Next out_pc is 0x100, 3 cycles later; no stale PC ever appears.
- Wrap-around: AW=8, RESET_PC=0xFE, INC=1 → out_pc 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-operation: assert rst with fifo_count=3 and inflight=1.
  - Next cycle: fifo_count=0, out_valid=0, imem_en=0.
  - After release: out_pc restarts at RESET_PC.
- Redirect with out_ready=1 and a full FIFO in the same cycle: no pop counted, FIFO empty after the edge, next issue address = redirect_pc.
